// File: rtl/williams_video_pkg.sv
`default_nettype none
// ============================================================================
// williams_video_pkg: shared widths, default blanking constants, lock states.
// Rev 1.0
// ============================================================================
package williams_video_pkg;

    localparam int PCNT_W = 11;
    localparam int LCNT_W = 11;

    localparam int HB_START_DEF = 336;
    localparam int HB_END_DEF   = 40;
    localparam int VB_START_DEF = 246;
    localparam int VB_END_DEF   = 6;

    typedef enum logic [1:0] {
        LOCK_UNLOCKED = 2'd0,
        LOCK_ACQUIRE  = 2'd1,
        LOCK_LOCKED   = 2'd2
    } lock_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// sync_edge: rising-edge detector; the history bit only samples when en=1.
// Rev 1.0
// ============================================================================
module sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic d,
    output logic rise
);

    logic r_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d <= 1'b0;
        end else if (en) begin
            r_d <= d;
        end
    end

    assign rise = en & d & ~r_d;

endmodule
`default_nettype wire

// File: rtl/williams_blank_gen.sv
`default_nettype none
// ============================================================================
// williams_blank_gen: regenerates pixel enable, blanking, beam position and a
// sync lock indication from the raw Williams SoC hs/vs.  Rev 1.0
// ============================================================================
module williams_blank_gen
    import williams_video_pkg::*;
#(
    parameter int HB_START    = HB_START_DEF,
    parameter int HB_END      = HB_END_DEF,
    parameter int VB_START    = VB_START_DEF,
    parameter int VB_END      = VB_END_DEF,
    parameter bit FORCE_BLANK = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic        ce_pix,
    output logic        hblank,
    output logic        vblank,
    output logic [9:0]  hpos,
    output logic [10:0] vpos,
    output logic [10:0] frame_lines,
    output logic        locked
);

    localparam logic [PCNT_W-2:0] c_hb_start = (PCNT_W-1)'(HB_START);
    localparam logic [PCNT_W-2:0] c_hb_end   = (PCNT_W-1)'(HB_END);
    localparam logic [LCNT_W-1:0] c_vb_start = LCNT_W'(VB_START);
    localparam logic [LCNT_W-1:0] c_vb_end   = LCNT_W'(VB_END);
    localparam logic [PCNT_W-1:0] c_pmax     = '1;
    localparam logic [LCNT_W-1:0] c_lmax     = '1;

    logic              w_hs_rise;
    logic              w_vs_rise;
    logic              w_sat;
    logic              w_ref_load;
    logic [PCNT_W-1:0] r_pcnt;
    logic [LCNT_W-1:0] r_lcnt;
    logic [LCNT_W-1:0] r_frame_lines;
    logic [LCNT_W-1:0] r_ref_lines;
    logic              r_hblank;
    logic              r_vblank;
    lock_state_t       r_state;
    lock_state_t       w_state_nxt;

    sync_edge u_hs_edge (
        .clk     (clk_sys),
        .reset_n (reset_n),
        .en      (1'b1),
        .d       (hs_in),
        .rise    (w_hs_rise)
    );

    // vs is only looked at on line starts, so its edge is line-aligned.
    sync_edge u_vs_edge (
        .clk     (clk_sys),
        .reset_n (reset_n),
        .en      (w_hs_rise),
        .d       (vs_in),
        .rise    (w_vs_rise)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_pcnt        <= '0;
            r_lcnt        <= '0;
            r_frame_lines <= '0;
        end else begin
            if (w_hs_rise) begin
                r_pcnt <= '0;
            end else if (r_pcnt != c_pmax) begin
                r_pcnt <= r_pcnt + 1'b1;
            end
            if (w_hs_rise) begin
                if (w_vs_rise) begin
                    r_frame_lines <= r_lcnt;
                    r_lcnt        <= '0;
                end else if (r_lcnt != c_lmax) begin
                    r_lcnt <= r_lcnt + 1'b1;
                end
            end
        end
    end

    // END comparison is checked first so that START==END leaves blanking off.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hblank <= 1'b1;
            r_vblank <= 1'b1;
        end else begin
            if (r_pcnt[PCNT_W-1:1] == c_hb_end) begin
                r_hblank <= 1'b0;
            end else if (r_pcnt[PCNT_W-1:1] == c_hb_start) begin
                r_hblank <= 1'b1;
            end
            if (r_lcnt == c_vb_end) begin
                r_vblank <= 1'b0;
            end else if (r_lcnt == c_vb_start) begin
                r_vblank <= 1'b1;
            end
        end
    end

    assign w_sat = (r_pcnt == c_pmax) | (r_lcnt == c_lmax);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= LOCK_UNLOCKED;
            r_ref_lines <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ref_load) begin
                r_ref_lines <= r_lcnt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ref_load  = 1'b0;
        if (w_sat) begin
            w_state_nxt = LOCK_UNLOCKED;
        end else if (w_vs_rise) begin
            case (r_state)
                LOCK_UNLOCKED: begin
                    w_state_nxt = LOCK_ACQUIRE;
                    w_ref_load  = 1'b1;
                end
                LOCK_ACQUIRE: begin
                    if (r_lcnt == r_ref_lines) begin
                        w_state_nxt = LOCK_LOCKED;
                    end else begin
                        w_ref_load = 1'b1;
                    end
                end
                LOCK_LOCKED: begin
                    if (r_lcnt != r_ref_lines) begin
                        w_state_nxt = LOCK_ACQUIRE;
                        w_ref_load  = 1'b1;
                    end
                end
                default: w_state_nxt = LOCK_UNLOCKED;
            endcase
        end
    end

    assign locked      = (r_state == LOCK_LOCKED);
    assign ce_pix      = r_pcnt[0];
    assign hpos        = r_pcnt[PCNT_W-1:1];
    assign vpos        = r_lcnt;
    assign frame_lines = r_frame_lines;
    assign hblank      = r_hblank | (FORCE_BLANK & ~locked);
    assign vblank      = r_vblank | (FORCE_BLANK & ~locked);

endmodule
`default_nettype wire

// File: tb/tb_williams_blank_gen.sv
`default_nettype none
// ============================================================================
// tb_williams_blank_gen: random sync streams against a frame-level model.
// Rev 1.0
// ============================================================================
module tb_williams_blank_gen;

    localparam int HBS = 20;
    localparam int HBE = 4;
    localparam int VBS = 10;
    localparam int VBE = 2;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        hs_in   = 1'b0;
    logic        vs_in   = 1'b0;
    logic        ce_pix;
    logic        hblank;
    logic        vblank;
    logic [9:0]  hpos;
    logic [10:0] vpos;
    logic [10:0] frame_lines;
    logic        locked;

    int checks = 0;
    int errors = 0;

    williams_blank_gen #(
        .HB_START    (HBS),
        .HB_END      (HBE),
        .VB_START    (VBS),
        .VB_END      (VBE),
        .FORCE_BLANK (1'b1)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .ce_pix      (ce_pix),
        .hblank      (hblank),
        .vblank      (vblank),
        .hpos        (hpos),
        .vpos        (vpos),
        .frame_lines (frame_lines),
        .locked      (locked)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference: pixel/line counts as plain integers, lock from the history
    // of line counts seen at frame starts since the last loss of sync.
    int  m_pcnt, m_lcnt, m_frame;
    bit  m_hs_d, m_vs_d, m_hb, m_vb, m_locked;
    int  hist[$];
    bit  saw_lock, saw_sat;

    task automatic model_reset();
        m_pcnt = 0; m_lcnt = 0; m_frame = 0;
        m_hs_d = 0; m_vs_d = 0; m_hb = 1; m_vb = 1; m_locked = 0;
        hist.delete();
    endtask

    task automatic model_update();
        bit hs_rise, vs_rise, sat;
        int pc_old, lc_old;
        hs_rise = hs_in && !m_hs_d;
        vs_rise = hs_rise && vs_in && !m_vs_d;
        pc_old  = m_pcnt;
        lc_old  = m_lcnt;
        sat     = (pc_old == 2047) || (lc_old == 2047);
        if ((pc_old / 2) == HBE) m_hb = 0;
        else if ((pc_old / 2) == HBS) m_hb = 1;
        if (lc_old == VBE) m_vb = 0;
        else if (lc_old == VBS) m_vb = 1;
        if (sat) hist.delete();
        else if (vs_rise) hist.push_back(lc_old);
        if (hist.size() > 2) void'(hist.pop_front());
        m_locked = (hist.size() == 2) && (hist[0] == hist[1]);
        m_pcnt = hs_rise ? 0 : ((pc_old < 2047) ? pc_old + 1 : 2047);
        if (hs_rise) begin
            if (vs_rise) begin
                m_frame = lc_old;
                m_lcnt  = 0;
            end else if (lc_old < 2047) begin
                m_lcnt = lc_old + 1;
            end
        end
        m_hs_d = hs_in;
        if (hs_rise) m_vs_d = vs_in;
    endtask

    function automatic logic [34:0] exp_vec();
        logic ce, hb, vb;
        ce = (m_pcnt % 2) == 1;
        hb = m_hb | ~m_locked;
        vb = m_vb | ~m_locked;
        return {ce, hb, vb, m_locked, 10'(m_pcnt / 2), 11'(m_lcnt), 11'(m_frame)};
    endfunction

    task automatic check_val(input string tag, input logic [34:0] got, input logic [34:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val(tag, {ce_pix, hblank, vblank, locked, hpos, vpos, frame_lines}, exp_vec());
        if (locked) saw_lock = 1;
        if (hpos == 10'h3ff) saw_sat = 1;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_update();
        @(negedge clk_sys);
        check_outputs("cycle");
    endtask

    task automatic drive_line(input int len, input int hsw, input bit vs);
        for (int c = 0; c < len; c++) begin
            hs_in = (c < hsw);
            vs_in = vs;
            tick();
        end
    endtask

    task automatic drive_frame(input int lines);
        int vsw;
        vsw = $urandom_range(1, 3);
        for (int l = 0; l < lines; l++)
            drive_line($urandom_range(44, 70), $urandom_range(1, 4), l < vsw);
    endtask

    initial begin
        int lines;
        saw_lock = 0;
        saw_sat  = 0;
        model_reset();

        // Reset held while hs toggles: outputs must stay at reset values.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_sys);
            hs_in = i[0];
            @(negedge clk_sys);
            check_outputs("reset_hold");
        end
        hs_in   = 1'b0;
        reset_n = 1'b1;

        drive_line(50, 2, 0);
        drive_line(50, 2, 0);

        for (int blk = 0; blk < 6; blk++) begin
            lines = $urandom_range(12, 16);
            for (int f = 0; f < 4; f++) drive_frame(lines);
            // a single frame of different length forces reacquisition
            if (blk == 2) drive_frame(lines - 2);
        end

        // hs stops: pixel counter saturates and lock is lost
        hs_in = 0;
        vs_in = 0;
        for (int i = 0; i < 2100; i++) tick();
        check_val("sat_hpos", {25'd0, hpos}, 35'h3ff);
        check_val("sat_lock", {32'd0, locked, hblank, vblank}, 35'b011);

        lines = $urandom_range(12, 16);
        for (int f = 0; f < 4; f++) drive_frame(lines);

        // asynchronous reset mid-line, away from any clock edge
        drive_line(23, 2, 0);
        @(posedge clk_sys);
        model_update();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            check_outputs("async_hold");
        end
        reset_n = 1'b1;

        lines = $urandom_range(12, 16);
        for (int f = 0; f < 4; f++) drive_frame(lines);

        check_val("saw_lock", {34'd0, saw_lock}, 35'd1);
        check_val("saw_sat", {34'd0, saw_sat}, 35'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
